// File: rtl/cache_pkg.sv
// Shared state encoding and address-field width helpers for the associative data cache.
// Pure declarations: no timing; backpressure is handled by the users of these types.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FETCH,
        FLUSH_SCAN,
        FLUSH_WB,
        HITCNT,
        DONE
    } dstate_t;

    function automatic int off_bits(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Byte address is 32 bits with two byte-offset bits below the word offset.
    function automatic int tag_bits(input int sets, input int block_words);
        return 30 - $clog2(sets) - $clog2(block_words);
    endfunction

endpackage

// File: rtl/dcache_assoc_if.sv
// Datapath and memory-controller signals of the data cache; slave is the cache view.
// No timing of its own; the memory side stalls the cache through dwait.
interface dcache_assoc_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache_lru.sv
// Per-set true-LRU age tracking and LRU way lookup for the data cache.
// Ages update on the clock edge of an access; lookup is combinational; no stalls.
module dcache_lru #(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     acc_vld,
    input  logic [$clog2(SETS)-1:0]  acc_set,
    input  logic [$clog2(WAYS)-1:0]  acc_way,
    input  logic [$clog2(SETS)-1:0]  qry_set,
    output logic [$clog2(WAYS)-1:0]  lru_way
);
    localparam int WW = $clog2(WAYS);

    logic [WW-1:0] age [SETS][WAYS];
    logic [WW-1:0] acc_age;

    assign acc_age = age[acc_set][acc_way];

    // Ages form a permutation per set: only ways younger than the accessed one shift up.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age[s][w] <= WW'(w);
                end
            end
        end else if (acc_vld) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WW'(w) == acc_way) begin
                    age[acc_set][w] <= '0;
                end else if (age[acc_set][w] < acc_age) begin
                    age[acc_set][w] <= age[acc_set][w] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age[qry_set][w] == WW'(WAYS - 1)) begin
                lru_way = WW'(w);
            end
        end
    end
endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-back/write-allocate data cache with halt flush and hit-count dump.
// Hits answer in the same cycle; misses stall on dwait for each memory word transferred.
module dcache_assoc
    import cache_pkg::*;
#(
    parameter int          SETS        = 8,
    parameter int          WAYS        = 2,
    parameter int          BLOCK_WORDS = 2,
    parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
    input logic           CLK,
    input logic           nRST,
    dcache_assoc_if.slave bus
);
    localparam int OW = off_bits(BLOCK_WORDS);
    localparam int IW = idx_bits(SETS);
    localparam int TW = tag_bits(SETS, BLOCK_WORDS);
    localparam int WW = $clog2(WAYS);

    typedef struct packed {
        logic [TW-1:0]                tag;
        logic                         valid;
        logic                         dirty;
        logic [BLOCK_WORDS-1:0][31:0] data;
    } row_t;

    row_t          rows [SETS][WAYS];
    dstate_t       state, next_state;
    logic [OW-1:0] wcnt;
    logic [WW-1:0] vway, fway;
    logic [IW-1:0] fset;
    logic [31:0]   hitcnt;
    logic          filled;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] idx;
    logic [OW-1:0] woff;
    logic          unused_byte;

    assign req_tag     = bus.dmemaddr[31 -: TW];
    assign idx         = bus.dmemaddr[2+OW +: IW];
    assign woff        = bus.dmemaddr[2 +: OW];
    assign unused_byte = ^bus.dmemaddr[1:0];

    logic          req, hit_any, inv_any, serve, wlast, flast, fill_done, flushing;
    logic [WW-1:0] hit_way, inv_way, lru_way, victim;
    logic [IW-1:0] op_set;
    logic [WW-1:0] op_way;
    row_t          op_row;

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rows[idx][w].valid && rows[idx][w].tag == req_tag) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
            if (!rows[idx][w].valid) begin
                inv_any = 1'b1;
                inv_way = WW'(w);
            end
        end
    end

    assign victim    = inv_any ? inv_way : lru_way;
    assign req       = bus.dmemREN | bus.dmemWEN;
    assign serve     = (state == IDLE) && !bus.halt && req && hit_any;
    assign wlast     = (wcnt == OW'(BLOCK_WORDS - 1));
    assign flast     = (fset == IW'(SETS - 1)) && (fway == WW'(WAYS - 1));
    assign fill_done = (state == FETCH) && !bus.dwait && wlast;
    assign flushing  = (state == FLUSH_SCAN) || (state == FLUSH_WB);
    assign op_set    = flushing ? fset : idx;
    assign op_way    = flushing ? fway : vway;
    assign op_row    = rows[op_set][op_way];

    dcache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
        .CLK     (CLK),
        .nRST    (nRST),
        .acc_vld (serve | fill_done),
        .acc_set (idx),
        .acc_way (serve ? hit_way : vway),
        .qry_set (idx),
        .lru_way (lru_way)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.halt)
                    next_state = FLUSH_SCAN;
                else if (req && !hit_any)
                    next_state = (rows[idx][victim].valid && rows[idx][victim].dirty) ? WB : FETCH;
            end
            WB:         if (!bus.dwait && wlast) next_state = FETCH;
            FETCH:      if (!bus.dwait && wlast) next_state = IDLE;
            FLUSH_SCAN: begin
                if (op_row.valid && op_row.dirty) next_state = FLUSH_WB;
                else if (flast)                   next_state = HITCNT;
            end
            FLUSH_WB:   if (!bus.dwait && wlast) next_state = flast ? HITCNT : FLUSH_SCAN;
            HITCNT:     if (!bus.dwait) next_state = DONE;
            default:    next_state = state;
        endcase
    end

    always_comb begin
        bus.dhit     = serve;
        bus.dmemload = '0;
        bus.flushed  = (state == DONE);
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        if (serve && bus.dmemREN) bus.dmemload = rows[idx][hit_way].data[woff];
        case (state)
            WB, FLUSH_WB: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = {op_row.tag, op_set, wcnt, 2'b00};
                bus.dstore = op_row.data[wcnt];
            end
            FETCH: begin
                bus.dREN  = 1'b1;
                bus.daddr = {req_tag, idx, wcnt, 2'b00};
            end
            HITCNT: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = HITCNT_ADDR;
                bus.dstore = hitcnt;
            end
            default: ;
        endcase
    end

    // The hit that completes a fill is the tail of a miss and is not counted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    rows[s][w] <= '0;
                end
            end
            wcnt   <= '0;
            vway   <= '0;
            fway   <= '0;
            fset   <= '0;
            hitcnt <= '0;
            filled <= 1'b0;
        end else begin
            filled <= 1'b0;
            case (state)
                IDLE: begin
                    fset <= '0;
                    fway <= '0;
                    wcnt <= '0;
                    if (serve) begin
                        if (!filled) hitcnt <= hitcnt + 32'd1;
                        if (bus.dmemWEN) begin
                            rows[idx][hit_way].data[woff] <= bus.dmemstore;
                            rows[idx][hit_way].dirty      <= 1'b1;
                        end
                    end else if (!bus.halt && req) begin
                        vway <= victim;
                    end
                end
                WB: if (!bus.dwait) wcnt <= wcnt + 1'b1;
                FETCH: if (!bus.dwait) begin
                    wcnt                         <= wcnt + 1'b1;
                    rows[idx][vway].data[wcnt]   <= bus.dload;
                    rows[idx][vway].valid        <= wlast;
                    if (wlast) begin
                        rows[idx][vway].tag   <= req_tag;
                        rows[idx][vway].dirty <= 1'b0;
                        filled                <= 1'b1;
                    end
                end
                FLUSH_SCAN: if (!(op_row.valid && op_row.dirty)) begin
                    fway <= fway + 1'b1;
                    if (fway == WW'(WAYS - 1)) fset <= fset + 1'b1;
                end
                FLUSH_WB: if (!bus.dwait) begin
                    wcnt <= wcnt + 1'b1;
                    if (wlast) begin
                        rows[fset][fway].dirty <= 1'b0;
                        fway <= fway + 1'b1;
                        if (fway == WW'(WAYS - 1)) fset <= fset + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_assoc.sv
// Table-driven bench for dcache_assoc with a scoreboarded memory model and hand-written
// flush and reset-mid-fetch sequences.
module tb_dcache_assoc;
    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    dcache_assoc_if bus();

    dcache_assoc #(
        .SETS(8), .WAYS(2), .BLOCK_WORDS(2), .HITCNT_ADDR(32'h3100)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] dat;
    } op_t;

    typedef struct {
        int  v;
        op_t op;
    } top_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rd;
        int          cyc;
        int          lat;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat      = 0;
    op_t         expq[$];
    vec_t        vecs[$];
    top_t        optab[$];
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic addv(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdv, input int cyc, input int l);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdat = wd; v.rd = rdv; v.cyc = cyc; v.lat = l;
        vecs.push_back(v);
    endtask

    task automatic addop(input logic wr, input logic [31:0] a, input logic [31:0] d);
        top_t t;
        t.v = vecs.size() - 1;
        t.op.wr = wr; t.op.addr = a; t.op.dat = d;
        optab.push_back(t);
    endtask

    task automatic pushop(input logic wr, input logic [31:0] a, input logic [31:0] d);
        op_t o;
        o.wr = wr; o.addr = a; o.dat = d;
        expq.push_back(o);
    endtask

    // Memory controller model: each word waits lat cycles with dwait high, then transfers.
    int          cnt = 0;
    logic        pw  = 1'b0;
    logic [31:0] pa  = '0;
    logic [31:0] ps  = '0;
    always @(negedge CLK) begin
        op_t e;
        if (nRST && (bus.dREN || bus.dWEN)) begin
            chk("ren_wen_exclusive", 32'(bus.dREN & bus.dWEN), 32'd0);
            if (pw) begin
                chk("daddr_stable", bus.daddr, pa);
                chk("dstore_stable", bus.dstore, ps);
            end
            if (cnt >= lat) begin
                bus.dwait = 1'b0;
                cnt = 0;
                if (expq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_op: wr %b addr %h data %h, none expected",
                             bus.dWEN, bus.daddr, bus.dstore);
                end else begin
                    e = expq.pop_front();
                    chk("op_kind", 32'(bus.dWEN), 32'(e.wr));
                    chk("op_addr", bus.daddr, e.addr);
                    if (e.wr) chk("op_data", bus.dstore, e.dat);
                end
                if (bus.dWEN) mem[bus.daddr] = bus.dstore;
                else          bus.dload = memrd(bus.daddr);
            end else begin
                bus.dwait = 1'b1;
                cnt++;
            end
            pw = bus.dwait;
            pa = bus.daddr;
            ps = bus.dstore;
        end else begin
            bus.dwait = 1'b1;
            cnt = 0;
            pw = 1'b0;
        end
    end

    task automatic access(input vec_t v, output logic [31:0] rd, output int cyc);
        bus.dmemREN   = !v.wr;
        bus.dmemWEN   = v.wr;
        bus.dmemaddr  = v.addr;
        bus.dmemstore = v.wdat;
        cyc = 0;
        rd  = '0;
        forever begin
            @(negedge CLK);
            if (bus.dhit) begin
                rd = bus.dmemload;
                break;
            end
            cyc++;
            if (cyc > 400) break;
        end
        @(posedge CLK);
        #1;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_dhit"},     32'(bus.dhit),    32'd0);
        chk({tag, "_dmemload"}, bus.dmemload,     32'd0);
        chk({tag, "_flushed"},  32'(bus.flushed), 32'd0);
        chk({tag, "_dREN"},     32'(bus.dREN),    32'd0);
        chk({tag, "_dWEN"},     32'(bus.dWEN),    32'd0);
        chk({tag, "_daddr"},    bus.daddr,        32'd0);
        chk({tag, "_dstore"},   bus.dstore,       32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc;
        logic        found;

        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        bus.halt      = 1'b0;

        // wr, addr, wdata, expected read, expected stall cycles, memory latency
        addv(0, 32'h40, 0, 32'h5A5A0040, 3, 0);  addop(0, 32'h40, 0); addop(0, 32'h44, 0);
        addv(0, 32'h40, 0, 32'h5A5A0040, 0, 0);
        addv(1, 32'h40, 32'hDEADBEEF, 0, 0, 0);
        addv(0, 32'h80, 0, 32'h5A5A0080, 3, 0);  addop(0, 32'h80, 0); addop(0, 32'h84, 0);
        addv(0, 32'hC0, 0, 32'h5A5A00C0, 25, 5);
        addop(1, 32'h40, 32'hDEADBEEF); addop(1, 32'h44, 32'h5A5A0044);
        addop(0, 32'hC0, 0);            addop(0, 32'hC4, 0);
        addv(0, 32'h84, 0, 32'h5A5A0084, 0, 0);
        addv(0, 32'h40, 0, 32'hDEADBEEF, 3, 0);  addop(0, 32'h40, 0); addop(0, 32'h44, 0);
        addv(0, 32'h80, 0, 32'h5A5A0080, 0, 0);
        addv(1, 32'h48, 32'h11111111, 0, 3, 0);  addop(0, 32'h48, 0); addop(0, 32'h4C, 0);
        addv(1, 32'h4C, 32'h22222222, 0, 0, 0);
        addv(1, 32'h50, 32'h33333333, 0, 3, 0);  addop(0, 32'h50, 0); addop(0, 32'h54, 0);
        addv(0, 32'h54, 0, 32'h5A5A0054, 0, 0);
        addv(1, 32'h44, 32'h44444444, 0, 0, 0);

        repeat (2) @(negedge CLK);
        chk_idle_outputs("reset");
        @(posedge CLK); #1 nRST = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            lat = vecs[i].lat;
            foreach (optab[j]) if (optab[j].v == i) expq.push_back(optab[j].op);
            access(vecs[i], rd, cyc);
            chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
            if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
            chk($sformatf("v%0d_ops_left", i), expq.size(), 0);
            expq.delete();
        end

        // Flush: three dirty blocks in scan order, then the hit count of seven.
        lat = 1;
        pushop(1, 32'h40, 32'hDEADBEEF); pushop(1, 32'h44, 32'h44444444);
        pushop(1, 32'h48, 32'h11111111); pushop(1, 32'h4C, 32'h22222222);
        pushop(1, 32'h50, 32'h33333333); pushop(1, 32'h54, 32'h5A5A0054);
        pushop(1, 32'h3100, 32'd7);
        bus.halt = 1'b1;
        for (int k = 0; k < 400 && !bus.flushed; k++) @(negedge CLK);
        chk("flushed_set", 32'(bus.flushed), 32'd1);
        chk("flush_ops_left", expq.size(), 0);
        expq.delete();

        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h40;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("done_dhit", 32'(bus.dhit), 32'd0);
            chk("done_flushed_sticky", 32'(bus.flushed), 32'd1);
            chk("done_mem_idle", 32'(bus.dREN | bus.dWEN), 32'd0);
        end
        @(posedge CLK); #1;
        bus.dmemREN = 1'b0;
        bus.halt    = 1'b0;
        nRST        = 1'b0;
        @(negedge CLK);
        chk("flushed_cleared_by_reset", 32'(bus.flushed), 32'd0);
        @(posedge CLK); #1 nRST = 1'b1;
        @(posedge CLK); #1;

        // Reset while the second word of a fill is outstanding.
        lat = 3;
        pushop(0, 32'h40, 0);
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h40;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (bus.dREN && bus.daddr == 32'h44) begin
                found = 1'b1;
                break;
            end
        end
        chk("fetch_word1_reached", 32'(found), 32'd1);
        nRST        = 1'b0;
        bus.dmemREN = 1'b0;
        #1;
        chk_idle_outputs("midfetch_reset");
        chk("midfetch_ops_left", expq.size(), 0);
        expq.delete();
        @(posedge CLK); #1 nRST = 1'b1;
        @(posedge CLK); #1;

        lat = 0;
        pushop(0, 32'h40, 0);
        pushop(0, 32'h44, 0);
        begin
            vec_t v;
            v.wr = 0; v.addr = 32'h40; v.wdat = 0; v.rd = 32'hDEADBEEF; v.cyc = 3; v.lat = 0;
            access(v, rd, cyc);
            chk("refetch_cycles", cyc, v.cyc);
            chk("refetch_rdata", rd, v.rd);
        end
        chk("refetch_ops_left", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
